// File: rtl/cmd_queue.sv
// ---------------------------------------------------------------------------
// cmd_queue : command front end for the game engine.
//
// Turns UART key bytes and four debounced button levels into state_type
// commands. Held buttons can auto-repeat. Commands are written into a FIFO
// that takes up to two pushes per cycle, and the engine drains it with a
// valid/ready handshake.
//
// Ports:
//   i_clk        clock
//   i_reset_n    synchronous active-low reset
//   i_rx_valid   one-cycle strobe, i_rx_byte is valid
//   i_rx_byte    received ASCII byte
//   i_btn_level  debounced button levels, 1 = pressed
//   i_flush      synchronous FIFO clear (also clears o_overflow)
//   i_cmd_ready  consumer pops the head entry this cycle
//   o_cmd_valid  FIFO non-empty
//   o_cmd        head entry, NONE when empty
//   o_count      current occupancy
//   o_overflow   sticky flag, a command was dropped
// ---------------------------------------------------------------------------
package cmd_queue_pkg;
   typedef enum logic [3:0] {
      NONE, LEFT, RIGHT, DOWN, DROP, HOLD, ROTATE, ROTATE_REV, BAR
   } state_type;
endpackage

module cmd_queue
   import cmd_queue_pkg::*;
#(
   parameter int         DEPTH         = 16,
   parameter int         REPEAT_DELAY  = 25_000_000,
   parameter int         REPEAT_PERIOD = 5_000_000,
   parameter logic [3:0] REPEAT_MASK   = 4'b1011
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_rx_valid,
   input  logic [7:0]                 i_rx_byte,
   input  logic [3:0]                 i_btn_level,
   input  logic                       i_flush,
   input  logic                       i_cmd_ready,
   output logic                       o_cmd_valid,
   output state_type                  o_cmd,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_overflow
);

   localparam int CW   = $clog2(DEPTH+1);
   localparam int FW   = CW + 1;
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam bit RPT_ON = (REPEAT_DELAY > 0);
   localparam logic [RW-1:0] DLY_LOAD = (REPEAT_DELAY > 0) ? RW'(REPEAT_DELAY - 1) : '0;
   localparam logic [RW-1:0] PER_LOAD = RW'(REPEAT_PERIOD - 1);

   state_type     r_mem [DEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic [3:0]    r_prevBtn;
   logic [3:0]    r_rptActive;
   logic [RW-1:0] r_rptCnt [4];

   logic          w_uartValid;
   state_type     w_uartCmd;
   logic [3:0]    w_press;
   logic [3:0]    w_fire;
   logic [3:0]    w_event;
   logic          w_btnValid;
   state_type     w_btnCmd;
   logic          w_pop;
   logic [FW-1:0] w_free;
   logic          w_acceptUart;
   logic          w_acceptBtn;
   logic          w_drop;
   logic [PW-1:0] w_wrNext;
   logic [PW-1:0] w_wrNext2;

   // Pointer increment with explicit wrap so non-power-of-two depths work.
   function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Keyboard decode: upper and lower case map to the same command.
   always_comb begin
      w_uartValid = 1'b0;
      w_uartCmd   = NONE;
      if (i_rx_valid) begin
         w_uartValid = 1'b1;
         case (i_rx_byte)
            8'h41, 8'h61:        w_uartCmd = LEFT;
            8'h44, 8'h64:        w_uartCmd = RIGHT;
            8'h53, 8'h73:        w_uartCmd = DOWN;
            8'h57, 8'h77, 8'h20: w_uartCmd = DROP;
            8'h43, 8'h63:        w_uartCmd = HOLD;
            8'h58, 8'h78:        w_uartCmd = ROTATE;
            8'h5A, 8'h7A:        w_uartCmd = ROTATE_REV;
            8'h42, 8'h62:        w_uartCmd = BAR;
            default:             w_uartValid = 1'b0;
         endcase
      end
   end

   // A button event is either a fresh press edge or an expired repeat
   // counter. A release in the same cycle as expiry suppresses the repeat.
   always_comb begin
      w_press = i_btn_level & ~r_prevBtn;
      for (int i = 0; i < 4; i++) begin
         w_fire[i] = RPT_ON && REPEAT_MASK[i] && r_rptActive[i] &&
                     i_btn_level[i] && (r_rptCnt[i] == '0);
      end
      w_event = w_press | w_fire;
   end

   // Only one button command per cycle, lowest index wins; others are lost.
   always_comb begin
      w_btnValid = 1'b1;
      w_btnCmd   = NONE;
      if (w_event[0])      w_btnCmd = RIGHT;
      else if (w_event[1]) w_btnCmd = DOWN;
      else if (w_event[2]) w_btnCmd = ROTATE;
      else if (w_event[3]) w_btnCmd = LEFT;
      else                 w_btnValid = 1'b0;
   end

   // Edge-detect register and per-button repeat counters. These keep running
   // through a flush so a held button keeps its repeat cadence.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_prevBtn   <= '0;
         r_rptActive <= '0;
         for (int i = 0; i < 4; i++) r_rptCnt[i] <= '0;
      end else begin
         r_prevBtn <= i_btn_level;
         for (int i = 0; i < 4; i++) begin
            if (!(RPT_ON && REPEAT_MASK[i])) begin
               r_rptActive[i] <= 1'b0;
            end else if (w_press[i]) begin
               r_rptActive[i] <= 1'b1;
               r_rptCnt[i]    <= DLY_LOAD;
            end else if (!i_btn_level[i]) begin
               r_rptActive[i] <= 1'b0;
            end else if (r_rptActive[i]) begin
               r_rptCnt[i] <= (r_rptCnt[i] == '0) ? PER_LOAD : r_rptCnt[i] - 1'b1;
            end
         end
      end
   end

   // Admission: a pop in this cycle frees its slot for this cycle's pushes.
   // The UART command is placed first so it takes the last free slot.
   always_comb begin
      w_pop        = i_cmd_ready && (r_count != '0);
      w_free       = FW'(DEPTH) - {1'b0, r_count} + FW'(w_pop);
      w_acceptUart = w_uartValid && (w_free != '0);
      w_acceptBtn  = w_btnValid && (w_free > FW'(w_acceptUart));
      w_drop       = (w_uartValid && !w_acceptUart) || (w_btnValid && !w_acceptBtn);
      w_wrNext     = nextPtr(r_wrPtr);
      w_wrNext2    = nextPtr(w_wrNext);
   end

   // Storage array; contents are meaningless outside the occupied window so
   // it needs no reset.
   always_ff @(posedge i_clk) begin
      if (i_reset_n && !i_flush) begin
         if (w_acceptUart) r_mem[r_wrPtr] <= w_uartCmd;
         if (w_acceptBtn)  r_mem[w_acceptUart ? w_wrNext : r_wrPtr] <= w_btnCmd;
      end
   end

   // Pointers, occupancy and the sticky overflow flag. Flush discards any
   // push or pop presented in the same cycle.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (i_flush) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_pop) r_rdPtr <= nextPtr(r_rdPtr);
         if (w_acceptUart && w_acceptBtn)     r_wrPtr <= w_wrNext2;
         else if (w_acceptUart || w_acceptBtn) r_wrPtr <= w_wrNext;
         r_count <= r_count + CW'(w_acceptUart) + CW'(w_acceptBtn) - CW'(w_pop);
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   // Outputs come from registered state only.
   assign o_cmd_valid = (r_count != '0);
   assign o_cmd       = (r_count != '0) ? r_mem[r_rdPtr] : NONE;
   assign o_count     = r_count;
   assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_cmd_queue : self-checking bench for cmd_queue.
// Directed scenarios followed by a randomized run, all checked every cycle
// against a queue-based reference model kept in this file.
// ---------------------------------------------------------------------------
module tb_cmd_queue;
   import cmd_queue_pkg::*;

   localparam int         DEPTH = 6;
   localparam int         RD    = 10;
   localparam int         RP    = 4;
   localparam logic [3:0] RMASK = 4'b1011;
   localparam int         CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rstN = 1'b0;
   logic          rxValid = 1'b0;
   logic [7:0]    rxByte = 8'h00;
   logic [3:0]    btnLevel = 4'h0;
   logic          flush = 1'b0;
   logic          cmdReady = 1'b0;
   logic          cmdValid;
   state_type     cmd;
   logic [CW-1:0] count;
   logic          overflow;

   cmd_queue #(
      .DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_MASK(RMASK)
   ) dut (
      .i_clk(clk), .i_reset_n(rstN), .i_rx_valid(rxValid), .i_rx_byte(rxByte),
      .i_btn_level(btnLevel), .i_flush(flush), .i_cmd_ready(cmdReady),
      .o_cmd_valid(cmdValid), .o_cmd(cmd), .o_count(count), .o_overflow(overflow)
   );

   always #5 clk = ~clk;

   int nVectors = 0;
   int nMiss    = 0;

   // Reference model state: the queue itself, sticky overflow, and for each
   // button the previous level plus the number of cycles since its press.
   state_type mQ[$];
   bit        mOvf = 1'b0;
   bit [3:0]  mPrev = '0;
   bit [3:0]  mTrack = '0;
   int        mSince[4] = '{0, 0, 0, 0};
   state_type btnMap[4] = '{RIGHT, DOWN, ROTATE, LEFT};

   function automatic state_type decodeByte(input logic [7:0] b, output bit ok);
      ok = 1'b1;
      case (b)
         "a", "A":      return LEFT;
         "d", "D":      return RIGHT;
         "s", "S":      return DOWN;
         "w", "W", " ": return DROP;
         "c", "C":      return HOLD;
         "x", "X":      return ROTATE;
         "z", "Z":      return ROTATE_REV;
         "b", "B":      return BAR;
         default: begin
            ok = 1'b0;
            return NONE;
         end
      endcase
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   task automatic modelStep();
      bit        btnOk;
      state_type btnCmd;
      bit        uOk;
      state_type uCmd;
      bit        ev;
      if (!rstN) begin
         mQ.delete();
         mOvf   = 1'b0;
         mPrev  = '0;
         mTrack = '0;
         for (int i = 0; i < 4; i++) mSince[i] = 0;
         return;
      end
      btnOk  = 1'b0;
      btnCmd = NONE;
      for (int i = 0; i < 4; i++) begin
         ev = 1'b0;
         if (btnLevel[i] && !mPrev[i]) begin
            ev        = 1'b1;
            mTrack[i] = (RD > 0) && RMASK[i];
            mSince[i] = 0;
         end else if (btnLevel[i] && mTrack[i]) begin
            mSince[i]++;
            if (mSince[i] >= RD && ((mSince[i] - RD) % RP) == 0) ev = 1'b1;
         end else if (!btnLevel[i]) begin
            mTrack[i] = 1'b0;
         end
         if (ev && !btnOk) begin
            btnOk  = 1'b1;
            btnCmd = btnMap[i];
         end
      end
      mPrev = btnLevel;
      uOk   = 1'b0;
      uCmd  = NONE;
      if (rxValid) uCmd = decodeByte(rxByte, uOk);
      if (flush) begin
         mQ.delete();
         mOvf = 1'b0;
      end else begin
         if (cmdReady && mQ.size() > 0) void'(mQ.pop_front());
         if (uOk) begin
            if (mQ.size() < DEPTH) mQ.push_back(uCmd);
            else mOvf = 1'b1;
         end
         if (btnOk) begin
            if (mQ.size() < DEPTH) mQ.push_back(btnCmd);
            else mOvf = 1'b1;
         end
      end
   endtask

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nVectors++;
      assert (obs === exp) else begin
         nMiss++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      state_type expCmd;
      expCmd = (mQ.size() > 0) ? mQ[0] : NONE;
      checkValue({tag, "/valid"}, 32'(cmdValid), 32'(mQ.size() > 0));
      checkValue({tag, "/cmd"}, 32'(cmd), 32'(expCmd));
      checkValue({tag, "/count"}, 32'(count), 32'(mQ.size()));
      checkValue({tag, "/overflow"}, 32'(overflow), 32'(mOvf));
   endtask

   task automatic applyStimulus(input bit rv, input logic [7:0] rb, input logic [3:0] bl,
                                input bit fl, input bit rdy, input string tag);
      rxValid  = rv;
      rxByte   = rb;
      btnLevel = bl;
      flush    = fl;
      cmdReady = rdy;
      modelStep();
      @(posedge clk);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      string fillS;
      string pool;
      logic [3:0] btnV;
      bit rv;
      bit rdy;
      bit fl;

      // Reset state
      rstN = 1'b0;
      applyStimulus(0, 8'h00, 4'h0, 0, 0, "reset");
      applyStimulus(0, 8'h00, 4'h0, 0, 0, "reset");
      checkValue("reset_count", 32'(count), 0);
      checkValue("reset_cmd", 32'(cmd), 32'(NONE));
      rstN = 1'b1;

      // UART decode with a pop every cycle
      applyStimulus(1, "a", 4'h0, 0, 1, "uart_a");
      checkValue("uart_a_head", 32'(cmd), 32'(LEFT));
      applyStimulus(1, "D", 4'h0, 0, 1, "uart_D");
      checkValue("uart_D_head", 32'(cmd), 32'(RIGHT));
      applyStimulus(1, " ", 4'h0, 0, 1, "uart_sp");
      checkValue("uart_sp_head", 32'(cmd), 32'(DROP));
      applyStimulus(1, "q", 4'h0, 0, 1, "uart_q");
      checkValue("uart_q_count", 32'(count), 0);

      // UART plus two simultaneous presses
      applyStimulus(1, "x", 4'b0101, 0, 0, "dual");
      checkValue("dual_count", 32'(count), 2);
      checkValue("dual_head", 32'(cmd), 32'(ROTATE));
      checkValue("dual_ovf", 32'(overflow), 0);
      applyStimulus(0, 8'h00, 4'b0000, 0, 1, "dual_pop1");
      checkValue("dual_second", 32'(cmd), 32'(RIGHT));
      applyStimulus(0, 8'h00, 4'b0000, 0, 1, "dual_pop2");

      // Auto-repeat on btn1, then a non-repeating btn2
      for (int i = 0; i < 30; i++) applyStimulus(0, 8'h00, 4'b0010, 0, 0, "rpt_hold");
      checkValue("rpt_count", 32'(count), 6);
      checkValue("rpt_ovf", 32'(overflow), 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 8'h00, 4'b0000, 0, 1, "rpt_drain");
      for (int i = 0; i < 30; i++) applyStimulus(0, 8'h00, 4'b0100, 0, 0, "norpt_hold");
      checkValue("norpt_count", 32'(count), 1);
      checkValue("norpt_head", 32'(cmd), 32'(ROTATE));
      applyStimulus(0, 8'h00, 4'b0000, 0, 1, "norpt_drain");

      // Full FIFO: drop without pop, accept with pop, order across wrap
      fillS = "adswcx";
      for (int i = 0; i < 6; i++) applyStimulus(1, fillS[i], 4'h0, 0, 0, "fill");
      applyStimulus(1, "s", 4'h0, 0, 0, "full_drop");
      checkValue("full_drop_ovf", 32'(overflow), 1);
      checkValue("full_drop_count", 32'(count), 6);
      applyStimulus(1, "s", 4'h0, 0, 1, "full_pop_push");
      checkValue("full_pop_count", 32'(count), 6);
      checkValue("full_pop_head", 32'(cmd), 32'(RIGHT));
      for (int i = 0; i < 6; i++) applyStimulus(0, 8'h00, 4'h0, 0, 1, "full_drain");

      // One free slot: UART wins, button dropped
      applyStimulus(0, 8'h00, 4'h0, 1, 0, "clr");
      checkValue("clr_ovf", 32'(overflow), 0);
      fillS = "adswx";
      for (int i = 0; i < 5; i++) applyStimulus(1, fillS[i], 4'h0, 0, 0, "fill5");
      applyStimulus(1, "c", 4'b1000, 0, 0, "oneslot");
      checkValue("oneslot_ovf", 32'(overflow), 1);
      checkValue("oneslot_count", 32'(count), 6);
      applyStimulus(0, 8'h00, 4'h0, 0, 0, "oneslot_rel");

      // Flush beats a same-cycle push and pop
      applyStimulus(1, "a", 4'h0, 1, 1, "flush");
      checkValue("flush_count", 32'(count), 0);
      checkValue("flush_cmd", 32'(cmd), 32'(NONE));
      checkValue("flush_ovf", 32'(overflow), 0);

      // Reset while a repeat is pending
      applyStimulus(0, 8'h00, 4'b0010, 0, 0, "rst_press");
      for (int i = 0; i < 4; i++) applyStimulus(0, 8'h00, 4'b0010, 0, 0, "rst_hold");
      rstN = 1'b0;
      for (int i = 0; i < 12; i++) applyStimulus(0, 8'h00, 4'b0010, 0, 0, "rst_in");
      checkValue("rst_in_count", 32'(count), 0);
      applyStimulus(0, 8'h00, 4'b0000, 0, 0, "rst_rel");
      rstN = 1'b1;
      for (int i = 0; i < 15; i++) applyStimulus(0, 8'h00, 4'b0000, 0, 0, "rst_idle");
      checkValue("rst_idle_count", 32'(count), 0);
      applyStimulus(0, 8'h00, 4'b0010, 0, 0, "rst_repress");
      checkValue("rst_repress_head", 32'(cmd), 32'(DOWN));
      applyStimulus(0, 8'h00, 4'b0000, 0, 1, "rst_repress_rel");

      // Randomized traffic
      pool = "aAdDsSwW cCxXzZbBq1";
      btnV = 4'h0;
      for (int n = 0; n < 1500; n++) begin
         int k;
         if ($urandom_range(0, 5) == 0) begin
            k = $urandom_range(0, 3);
            btnV[k] = ~btnV[k];
         end
         rv   = ($urandom_range(0, 2) == 0);
         rdy  = ($urandom_range(0, 2) != 0);
         fl   = ($urandom_range(0, 59) == 0);
         rstN = ($urandom_range(0, 199) != 0);
         k    = $urandom_range(0, pool.len() - 1);
         applyStimulus(rv, pool[k], btnV, fl, rdy, "random");
      end
      rstN = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
      $finish;
   end

endmodule

// File: doc/cmd_queue.md
Name: cmd_queue

Overview:
Parametrised successor to the game's input-control front end. It decodes UART key bytes and four debounced button levels into state_type commands, and adds per-button auto-repeat (DAS) for held buttons. Commands go into a FIFO of configurable depth that accepts two pushes per cycle, and the game engine drains that FIFO through a valid/ready handshake. The block sits between the uart/debouncer instances and the game FSM, and adds flush and overflow reporting.

Parameters:
DEPTH, 16, FIFO entries; any value >= 2.
REPEAT_DELAY, 25_000_000, cycles from press to first auto-repeat; 0 disables auto-repeat entirely.
REPEAT_PERIOD, 5_000_000, cycles between subsequent repeats; must be >= 1.
REPEAT_MASK, 4'b1011, per-button repeat enable (bit i = btn_level[i]).

Ports:
clk  in  1  clock.
reset_n  in  1  synchronous active-low reset.
rx_valid  in  1  one-cycle strobe: rx_byte is valid.
rx_byte  in  8  received ASCII byte.
btn_level  in  4  debounced button levels, 1 = pressed.
flush  in  1  synchronous FIFO clear.
cmd_ready  in  1  consumer pops the head entry this cycle.
cmd_valid  out  1  FIFO non-empty.
cmd  out  state_type  head entry; NONE when empty.
count  out  $clog2(DEPTH+1)  current occupancy.
overflow  out  1  sticky flag: a command was dropped.

Behaviour:
- Reset: takes effect at posedge clk when reset_n=0. Clears FIFO, pointers and count, and sets cmd_valid=0, cmd=NONE, overflow=0. All repeat counters go idle and the previous-button register is cleared. Reset overrides every other input.
- UART decode (only when rx_valid=1):
  - A/a=LEFT, D/d=RIGHT, S/s=DOWN.
  - W/w/space=DROP, C/c=HOLD.
  - X/x=ROTATE, Z/z=ROTATE_REV, B/b=BAR.
  - Any other byte: no push, no overflow.
- Button map: btn[0]=RIGHT, btn[1]=DOWN, btn[2]=ROTATE, btn[3]=LEFT.
- Button events:
  - A press fires when btn_level[i] is 1 and the registered value from the previous cycle is 0.
  - A repeat fires when button i's counter expires.
  - Only one button event is pushed per cycle, chosen by lowest index.
  - Losing button events are discarded silently: no overflow, no retry.
- Repeat counters (per button i, used only when REPEAT_MASK[i]=1 and REPEAT_DELAY>0):
  - On a press, load REPEAT_DELAY-1.
  - While held, decrement each cycle.
  - At 0, fire a repeat and reload REPEAT_PERIOD-1.
  - On release, go idle with no event.
  - First repeat comes REPEAT_DELAY cycles after the press cycle, then one every REPEAT_PERIOD cycles.
- Push order: the UART command is written before the button command in the same cycle, so UART lands nearer the head.
- Free slots = DEPTH - count + (cmd_ready & cmd_valid). A pop frees its slot in the same cycle.
  - Two pushes with one free slot: UART accepted, button dropped, overflow<=1.
  - Push with zero free slots: dropped, overflow<=1.
- Pop: when cmd_ready=1 and cmd_valid=1, the head advances. cmd_ready while empty is ignored, and count never underflows.
- Latency: a push into an empty FIFO is visible on cmd/cmd_valid the next cycle. cmd and cmd_valid are registered or derived from registered state only, with no combinational path from any input.
- Pointers wrap from DEPTH-1 to 0, for any DEPTH including non-powers of two. count = previous count + pushes accepted - pop.
- flush=1 clears the FIFO and count and clears overflow. Pushes and pops in the same cycle are discarded. Repeat counters and the previous-button register keep running.

Test Plan:
- Reset then rx_valid with "a", "D", " ", "q": next cycles give cmd_valid=1, cmd LEFT, then RIGHT, then DROP with cmd_ready=1 each cycle; "q" pushes nothing; count ends at 0.
- Same cycle rx "x" plus btn_level 4'b0000->4'b0101: queue holds ROTATE (UART) then RIGHT (btn0); btn2 is dropped; count=2, overflow=0.
- REPEAT_DELAY=10, REPEAT_PERIOD=4, hold btn[1] for 30 cycles, no pops: DOWN pushed at cycles 0, 10, 14, 18, 22, 26 (six entries). The same hold on btn[2] (mask 0) gives exactly one ROTATE.
- DEPTH=4: fill with 4 commands, then rx "s" with cmd_ready=0 -> dropped, overflow=1, count=4. Repeat with cmd_ready=1 -> accepted, count stays 4, and the pointer wrap keeps order.
- One free slot, simultaneous UART "c" plus btn3 press -> HOLD accepted, LEFT dropped, overflow=1.
- Mid-stream flush=1 together with an rx "a" push and a pop -> next cycle count=0, cmd=NONE, overflow=0. Assert reset_n=0 while btn is held with a repeat pending -> no event afterward until release and re-press.
